// File: rtl/cpu_debug_vjtag_host_driver_if.sv
// Command/response handshake bundle for the virtual-JTAG host driver.
// The master side offers (IR, DR) commands; the slave side returns the captured DR and IR status.
interface cpu_debug_vjtag_host_driver_if #(
    parameter int DR_W = 38,
    parameter int IR_W = 2
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [IR_W-1:0] cmd_ir;
    logic [DR_W-1:0] cmd_dr;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DR_W-1:0] rsp_dr;
    logic [IR_W-1:0] rsp_ir_out;

    modport master (
        output cmd_valid, cmd_ir, cmd_dr, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_dr, rsp_ir_out
    );

    modport slave (
        input  cmd_valid, cmd_ir, cmd_dr, rsp_ready,
        output cmd_ready, rsp_valid, rsp_dr, rsp_ir_out
    );
endinterface

// File: rtl/cpu_debug_vjtag_host_driver.sv
// Host-side initiator for the Nios II debug-slave virtual-JTAG port: UIR/CDR/SDR/UDR/RTI strobes plus generated TCK.
// Define CPU_DEBUG_VJTAG_IR_CACHE_EN to skip the UIR period when a command repeats the last loaded instruction.
module cpu_debug_vjtag_host_driver #(
    parameter int DR_W     = 38,
    parameter int IR_W     = 2,
    parameter int TCK_HALF = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    cpu_debug_vjtag_host_driver_if.slave bus,
    output logic                  vji_tck,
    output logic                  vji_tdi,
    input  logic                  vji_tdo,
    output logic [IR_W-1:0]       vji_ir_in,
    input  logic [IR_W-1:0]       vji_ir_out,
    output logic                  vji_uir,
    output logic                  vji_cdr,
    output logic                  vji_sdr,
    output logic                  vji_udr,
    output logic                  vji_rti
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UIR,
        S_CDR,
        S_SHIFT,
        S_UDR,
        S_RTI,
        S_RESP
    } state_t;

    localparam int              PH_W    = $clog2(2 * TCK_HALF);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * TCK_HALF - 1);
    localparam logic [PH_W-1:0] PH_RISE = PH_W'(TCK_HALF);
    localparam int              BC_W    = $clog2(DR_W + 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DR_W - 1);

    state_t          state;
    state_t          state_next;
    logic [PH_W-1:0] ph;
    logic [BC_W-1:0] bit_cnt;
    logic [DR_W-1:0] din_sr;
    logic [DR_W-1:0] cap_sr;
    logic [DR_W-1:0] rsp_dr_q;
    logic [IR_W-1:0] ir_q;
    logic [IR_W-1:0] ir_cap;
    logic [IR_W-1:0] rsp_ir_q;
    logic            cmd_ready_q;
    logic            rsp_valid_q;

    logic            active;
    logic            period_end;
    logic            rise_edge;
    logic            accept;
    logic            rsp_done;
    logic            ir_hit;

    assign active     = (state != S_IDLE) && (state != S_RESP);
    assign period_end = active && (ph == PH_LAST);
    assign rise_edge  = active && (ph == PH_RISE);
    assign accept     = (state == S_IDLE) && bus.cmd_valid && cmd_ready_q;
    assign rsp_done   = rsp_valid_q && bus.rsp_ready;

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_dr     = rsp_dr_q;
    assign bus.rsp_ir_out = rsp_ir_q;

`ifdef CPU_DEBUG_VJTAG_IR_CACHE_EN
    logic            ir_cache_vld;
    logic [IR_W-1:0] ir_cache;

    assign ir_hit = ir_cache_vld && (bus.cmd_ir == ir_cache);

    // The slave already holds ir_cache, so a matching command can go straight to CDR.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_cache_vld <= 1'b0;
            ir_cache     <= '0;
        end else if (accept && !ir_hit) begin
            ir_cache_vld <= 1'b1;
            ir_cache     <= bus.cmd_ir;
        end
    end
`else
    assign ir_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: default assignment first, so no path through the case leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = ir_hit ? S_CDR : S_UIR;
            S_UIR:   if (period_end) state_next = S_CDR;
            S_CDR:   if (period_end) state_next = S_SHIFT;
            S_SHIFT: if (period_end && (bit_cnt == BC_LAST)) state_next = S_UDR;
            S_UDR:   if (period_end) state_next = S_RTI;
            S_RTI:   if (period_end) state_next = S_RESP;
            S_RESP:  if (rsp_done) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Pins are registered from the current (state, phase), so they trail the state register by one clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            ph          <= '0;
            bit_cnt     <= '0;
            din_sr      <= '0;
            cap_sr      <= '0;
            ir_q        <= '0;
            ir_cap      <= '0;
            rsp_dr_q    <= '0;
            rsp_ir_q    <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            vji_tck     <= 1'b0;
            vji_tdi     <= 1'b0;
            vji_ir_in   <= '0;
            vji_uir     <= 1'b0;
            vji_cdr     <= 1'b0;
            vji_sdr     <= 1'b0;
            vji_udr     <= 1'b0;
            vji_rti     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register here samples pre-edge values.
            if (active && !period_end) ph <= ph + 1'b1;
            else                       ph <= '0;

            if (accept) begin
                din_sr  <= bus.cmd_dr;
                ir_q    <= bus.cmd_ir;
                bit_cnt <= '0;
            end else if ((state == S_SHIFT) && period_end) begin
                din_sr  <= din_sr >> 1;
                bit_cnt <= bit_cnt + 1'b1;
            end

            // tdo / ir_out are taken on the clk where TCK rises, before the slave updates them.
            if ((state == S_SHIFT) && rise_edge) cap_sr <= {vji_tdo, cap_sr[DR_W-1:1]};
            if ((state == S_UIR) && rise_edge)   ir_cap <= vji_ir_out;

            if ((state == S_RESP) && !rsp_valid_q) begin
                rsp_dr_q <= cap_sr;
                rsp_ir_q <= ir_cap;
            end

            cmd_ready_q <= (state == S_IDLE) && !accept;
            rsp_valid_q <= (state == S_RESP) && !rsp_done;

            vji_tck <= active && (ph >= PH_RISE);
            vji_tdi <= (state == S_SHIFT) && din_sr[0];
            vji_uir <= (state == S_UIR);
            vji_cdr <= (state == S_CDR);
            vji_sdr <= (state == S_SHIFT);
            vji_udr <= (state == S_UDR);
            vji_rti <= (state == S_RTI);
            if (state == S_UIR) vji_ir_in <= ir_q;
        end
    end

endmodule

// File: tb/tb_cpu_debug_vjtag_host_driver.sv
// Self-checking bench: two drivers (TCK_HALF=2 directed, TCK_HALF=1 random) against a debug-slave shift-register model.
// Build with CPU_DEBUG_VJTAG_IR_CACHE_EN defined to exercise the IR cache expectations.
module tb_cpu_debug_vjtag_host_driver;

    localparam int DR_W = 38;
    localparam int IR_W = 2;
    localparam int N    = 2;
`ifdef CPU_DEBUG_VJTAG_IR_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    typedef struct {
        logic [IR_W-1:0] ir;
        logic [DR_W-1:0] dr;
        logic [DR_W-1:0] pre;
        logic [IR_W-1:0] iro;
        int              hold;
        logic [DR_W-1:0] exp_dr;
        logic [IR_W-1:0] exp_ir;
        int              exp_lat;
        int              exp_uir;
    } vec_t;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    logic            cmd_valid [N];
    logic [IR_W-1:0] cmd_ir    [N];
    logic [DR_W-1:0] cmd_dr    [N];
    logic            rsp_ready [N];
    logic [DR_W-1:0] sr_pre    [N];
    logic [IR_W-1:0] ir_out_m  [N];

    wire             cmd_ready_w [N];
    wire             rsp_valid_w [N];
    wire [DR_W-1:0]  rsp_dr_w    [N];
    wire [IR_W-1:0]  rsp_ir_w    [N];
    wire             tck_w       [N];
    wire [4:0]       strb_w      [N];
    wire [IR_W-1:0]  ir_in_w     [N];
    wire [DR_W-1:0]  udr_sr_w    [N];
    wire [31:0]      n_uir_w     [N];
    wire [31:0]      n_cdr_w     [N];
    wire [31:0]      n_sdr_w     [N];
    wire [31:0]      n_udr_w     [N];
    wire [31:0]      n_rti_w     [N];
    wire [31:0]      n_ovl_w     [N];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < N; g++) begin : g_dut
        cpu_debug_vjtag_host_driver_if #(.DR_W(DR_W), .IR_W(IR_W)) bus ();
        logic            tck, tdi, tdo, uir, cdr, sdr, udr, rti;
        logic [IR_W-1:0] ir_in;
        logic [DR_W-1:0] sr = '0;
        logic [DR_W-1:0] udr_sr = '0;
        int n_uir = 0, n_cdr = 0, n_sdr = 0, n_udr = 0, n_rti = 0, n_ovl = 0;

        assign bus.cmd_valid = cmd_valid[g];
        assign bus.cmd_ir    = cmd_ir[g];
        assign bus.cmd_dr    = cmd_dr[g];
        assign bus.rsp_ready = rsp_ready[g];

        cpu_debug_vjtag_host_driver #(.DR_W(DR_W), .IR_W(IR_W), .TCK_HALF(g == 0 ? 2 : 1)) u_dut (
            .clk        (clk),
            .reset      (reset),
            .bus        (bus),
            .vji_tck    (tck),
            .vji_tdi    (tdi),
            .vji_tdo    (tdo),
            .vji_ir_in  (ir_in),
            .vji_ir_out (ir_out_m[g]),
            .vji_uir    (uir),
            .vji_cdr    (cdr),
            .vji_sdr    (sdr),
            .vji_udr    (udr),
            .vji_rti    (rti)
        );

        // Debug-slave model: parallel capture at CDR, LSB-first shift at SDR, snapshot at UDR.
        assign tdo = sr[0];
        always @(posedge tck) begin
            if (cdr)      sr <= sr_pre[g];
            else if (sdr) sr <= {tdi, sr[DR_W-1:1]};
            if (udr) udr_sr <= sr;
            n_uir <= n_uir + int'(uir);
            n_cdr <= n_cdr + int'(cdr);
            n_sdr <= n_sdr + int'(sdr);
            n_udr <= n_udr + int'(udr);
            n_rti <= n_rti + int'(rti);
        end
        always @(negedge clk) if (!$onehot0({uir, cdr, sdr, udr, rti})) n_ovl <= n_ovl + 1;

        assign cmd_ready_w[g] = bus.cmd_ready;
        assign rsp_valid_w[g] = bus.rsp_valid;
        assign rsp_dr_w[g]    = bus.rsp_dr;
        assign rsp_ir_w[g]    = bus.rsp_ir_out;
        assign tck_w[g]       = tck;
        assign strb_w[g]      = {uir, cdr, sdr, udr, rti};
        assign ir_in_w[g]     = ir_in;
        assign udr_sr_w[g]    = udr_sr;
        assign n_uir_w[g]     = n_uir;
        assign n_cdr_w[g]     = n_cdr;
        assign n_sdr_w[g]     = n_sdr;
        assign n_udr_w[g]     = n_udr;
        assign n_rti_w[g]     = n_rti;
        assign n_ovl_w[g]     = n_ovl;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected cycles from accepting edge to rsp_valid: one TCK period per state, plus one register stage.
    function automatic int exp_latency(input int d, input bit hit);
        int th;
        th = (d == 0) ? 2 : 1;
        return 1 + (DR_W + 4 - int'(hit)) * 2 * th;
    endfunction

    task automatic run_cmd(input int d, input logic [IR_W-1:0] ir, input logic [DR_W-1:0] dr,
                           input logic [DR_W-1:0] pre, input logic [IR_W-1:0] iro, input int hold,
                           output int lat, output logic [DR_W-1:0] rdr, output logic [IR_W-1:0] rir,
                           output int du, output int dc, output int ds, output int dd, output int dr_n);
        int   acc, u0, c0, s0, d0, r0;
        logic tck_hold;
        bit   stable;
        lat = -1; rdr = '0; rir = '0; du = -1; dc = -1; ds = -1; dd = -1; dr_n = -1;
        u0 = int'(n_uir_w[d]); c0 = int'(n_cdr_w[d]); s0 = int'(n_sdr_w[d]);
        d0 = int'(n_udr_w[d]); r0 = int'(n_rti_w[d]);
        sr_pre[d] = pre;
        ir_out_m[d] = iro;
        @(negedge clk);
        cmd_ir[d] = ir;
        cmd_dr[d] = dr;
        cmd_valid[d] = 1'b1;
        for (int w = 0; w < 50 && !cmd_ready_w[d]; w++) @(negedge clk);
        check("cmd_accept", 64'(cmd_ready_w[d]), 64'd1);
        if (!cmd_ready_w[d]) begin
            cmd_valid[d] = 1'b0;
            return;
        end
        acc = cyc + 1;
        @(negedge clk);
        cmd_valid[d] = 1'b0;
        cmd_ir[d] = ~ir;
        cmd_dr[d] = ~dr;
        check("ready_low_busy", 64'(cmd_ready_w[d]), 64'd0);
        for (int w = 0; w < 1000 && !rsp_valid_w[d]; w++) @(negedge clk);
        check("rsp_arrive", 64'(rsp_valid_w[d]), 64'd1);
        if (!rsp_valid_w[d]) return;
        lat = cyc - acc;
        rdr = rsp_dr_w[d];
        rir = rsp_ir_w[d];
        if (hold > 0) begin
            stable = 1'b1;
            tck_hold = tck_w[d];
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                if (!rsp_valid_w[d] || rsp_dr_w[d] !== rdr || rsp_ir_w[d] !== rir ||
                    cmd_ready_w[d] || tck_w[d] !== tck_hold || strb_w[d] != '0) stable = 1'b0;
            end
            check("hold_stable", 64'(stable), 64'd1);
        end
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        check("rsp_drop", 64'(rsp_valid_w[d]), 64'd0);
        @(negedge clk);
        check("b2b_ready", 64'(cmd_ready_w[d]), 64'd1);
        du = int'(n_uir_w[d]) - u0; dc = int'(n_cdr_w[d]) - c0; ds = int'(n_sdr_w[d]) - s0;
        dd = int'(n_udr_w[d]) - d0; dr_n = int'(n_rti_w[d]) - r0;
    endtask

    initial begin
        vec_t            vec [4];
        int              lat, du, dc, ds, dd, dr_n, ud0;
        logic [DR_W-1:0] rdr, rnd_dr, rnd_pre;
        logic [IR_W-1:0] rir, rnd_ir, rnd_iro;
        bit              mvalid, hit, seen;
        logic [IR_W-1:0] mir, mirout;

        vec[0] = '{ir: 2'b01, dr: 38'h15_5555_5555, pre: 38'h2A_AAAA_AAAA, iro: 2'b10, hold: 20,
                   exp_dr: 38'h2A_AAAA_AAAA, exp_ir: 2'b10, exp_lat: 169, exp_uir: 1};
        vec[1] = '{ir: 2'b00, dr: 38'h3F_FFFF_FFFF, pre: 38'h0, iro: 2'b01, hold: 0,
                   exp_dr: 38'h0, exp_ir: 2'b01, exp_lat: 169, exp_uir: 1};
        vec[2] = '{ir: 2'b00, dr: 38'h0, pre: 38'h3F_FFFF_FFFF, iro: 2'b11, hold: 0,
                   exp_dr: 38'h3F_FFFF_FFFF, exp_ir: (CACHE_EN ? 2'b01 : 2'b11),
                   exp_lat: (CACHE_EN ? 165 : 169), exp_uir: (CACHE_EN ? 0 : 1)};
        vec[3] = '{ir: 2'b11, dr: 38'h20_0000_0001, pre: 38'h00_8000_0001, iro: 2'b00, hold: 3,
                   exp_dr: 38'h00_8000_0001, exp_ir: 2'b00, exp_lat: 169, exp_uir: 1};

        for (int d = 0; d < N; d++) begin
            cmd_valid[d] = 1'b0; cmd_ir[d] = '0; cmd_dr[d] = '0; rsp_ready[d] = 1'b0;
            sr_pre[d] = '0; ir_out_m[d] = '0;
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_strobes", 64'(strb_w[0]), 64'd0);
        check("rst_tck", 64'(tck_w[0]), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid_w[0]), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready_w[0]), 64'd0);
        check("rst_rsp_dr", 64'(rsp_dr_w[0]), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 64'(cmd_ready_w[0]), 64'd1);

        for (int i = 0; i < 4; i++) begin
            run_cmd(0, vec[i].ir, vec[i].dr, vec[i].pre, vec[i].iro, vec[i].hold,
                    lat, rdr, rir, du, dc, ds, dd, dr_n);
            check("vec_latency", 64'(lat), 64'(vec[i].exp_lat));
            check("vec_rsp_dr", 64'(rdr), 64'(vec[i].exp_dr));
            check("vec_rsp_ir", 64'(rir), 64'(vec[i].exp_ir));
            check("vec_slave_sr", 64'(udr_sr_w[0]), 64'(vec[i].dr));
            check("vec_ir_in", 64'(ir_in_w[0]), 64'(vec[i].ir));
            check("vec_n_uir", 64'(du), 64'(vec[i].exp_uir));
            check("vec_n_cdr", 64'(dc), 64'd1);
            check("vec_n_sdr", 64'(ds), 64'(DR_W));
            check("vec_n_udr", 64'(dd), 64'd1);
            check("vec_n_rti", 64'(dr_n), 64'd1);
        end

        // Reset held three clocks in the middle of SHIFT must abort without UDR or response.
        sr_pre[0] = 38'h12_3456_789A;
        @(negedge clk);
        cmd_ir[0] = 2'b10; cmd_dr[0] = 38'h0F_0F0F_0F0F; cmd_valid[0] = 1'b1;
        for (int w = 0; w < 50 && !cmd_ready_w[0]; w++) @(negedge clk);
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        for (int w = 0; w < 200 && !strb_w[0][2]; w++) @(negedge clk);
        check("reach_shift", 64'(strb_w[0][2]), 64'd1);
        repeat (10) @(negedge clk);
        ud0 = int'(n_udr_w[0]);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_strobes", 64'(strb_w[0]), 64'd0);
        check("rst_mid_tck", 64'(tck_w[0]), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 250; k++) begin
            @(negedge clk);
            if (rsp_valid_w[0]) seen = 1'b1;
        end
        check("rst_no_rsp", 64'(seen), 64'd0);
        check("rst_no_udr", 64'(int'(n_udr_w[0]) - ud0), 64'd0);
        check("rst_ready", 64'(cmd_ready_w[0]), 64'd1);

        // After reset the IR cache is invalid, so repeating the last IR must still run UIR.
        run_cmd(0, 2'b11, 38'h00_0000_00FF, 38'h3C_0000_0003, 2'b01, 0, lat, rdr, rir, du, dc, ds, dd, dr_n);
        check("post_rst_latency", 64'(lat), 64'd169);
        check("post_rst_n_uir", 64'(du), 64'd1);
        check("post_rst_rsp_ir", 64'(rir), 64'(2'b01));
        check("post_rst_rsp_dr", 64'(rdr), 64'(38'h3C_0000_0003));

        // Randomized commands on the TCK_HALF=1 instance against the slave and IR-cache model.
        mvalid = 1'b0; mir = '0; mirout = '0;
        for (int r = 0; r < 100; r++) begin
            rnd_ir  = IR_W'($urandom_range(0, 3));
            rnd_iro = IR_W'($urandom_range(0, 3));
            rnd_dr  = DR_W'({$urandom(), $urandom()});
            rnd_pre = DR_W'({$urandom(), $urandom()});
            hit = CACHE_EN && mvalid && (rnd_ir == mir);
            if (!hit) begin
                mvalid = 1'b1;
                mir    = rnd_ir;
                mirout = rnd_iro;
            end
            run_cmd(1, rnd_ir, rnd_dr, rnd_pre, rnd_iro, 0, lat, rdr, rir, du, dc, ds, dd, dr_n);
            check("rnd_latency", 64'(lat), 64'(exp_latency(1, hit)));
            check("rnd_rsp_dr", 64'(rdr), 64'(rnd_pre));
            check("rnd_slave_sr", 64'(udr_sr_w[1]), 64'(rnd_dr));
            check("rnd_rsp_ir", 64'(rir), 64'(mirout));
            check("rnd_ir_in", 64'(ir_in_w[1]), 64'(mir));
            check("rnd_n_sdr", 64'(ds), 64'(DR_W));
        end

        check("strobe_overlap0", 64'(n_ovl_w[0]), 64'd0);
        check("strobe_overlap1", 64'(n_ovl_w[1]), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
